// File: rtl/glitch_pkg.sv
// Shared definitions for the glitcher host-report path: frame constants,
// report codes, transmitter state encoding and the frame checksum helper.
package glitch_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES       = 7;

  localparam logic [7:0] RPT_GLITCH_DONE = 8'h01;
  localparam logic [7:0] RPT_TGT_RESET   = 8'h02;
  localparam logic [7:0] RPT_OFFSET      = 8'h10;
  localparam logic [7:0] RPT_DURATION    = 8'h11;
  localparam logic [7:0] RPT_ERROR       = 8'hEE;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_t;

  // Checksum covers the code and the four payload bytes; sync is excluded and
  // the 8-bit sum simply wraps.
  function automatic logic [7:0] frame_checksum(input logic [7:0]  code,
                                                input logic [31:0] data);
    return code + data[31:24] + data[23:16] + data[15:8] + data[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start pulse loads a byte and begins its start bit in
// the next cycle; done pulses in the last cycle of the stop bit so the parent
// can chain the next byte with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;
  logic             active;
  logic             tx_q;
  logic             last_clk;

  assign last_clk = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign done     = active && last_clk && (bit_idx == 4'd9);
  assign tx       = tx_q;

  // Bit timer and shifter: bit_idx 0 is the start bit, 1..8 data LSB first,
  // 9 the stop bit; ones are shifted in so the stop level falls out naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q    <= 1'b1;
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (start) begin
      tx_q    <= 1'b0;
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
    end else if (active) begin
      if (last_clk) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          tx_q    <= 1'b1;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx_q    <= shreg[0];
          shreg   <= {1'b1, shreg[7:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/glitch_report_tx.sv
// Host-bound report transmitter: accepts one code/payload report per
// handshake, frames it as SYNC, CODE, D3..D0, CHK and sends it 8N1.
module glitch_report_tx
  import glitch_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_code,
  input  logic [31:0] req_data,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("glitch_report_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  tx_state_t   state, state_nxt;
  logic [2:0]  byte_idx, byte_idx_nxt;
  logic [7:0]  code_q;
  logic [31:0] data_q;
  logic [7:0]  chk_q;
  logic        req_ready_q;
  logic        accept;
  logic        byte_start;
  logic [7:0]  byte_data;
  logic        byte_done;

  assign accept    = req_valid && req_ready_q;
  assign req_ready = req_ready_q;
  assign busy      = (state == ST_SEND);

  // Next-state logic: start the sync byte on accept, chain each following
  // byte on the serialiser's done pulse, and return to idle after the checksum.
  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    byte_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt    = ST_SEND;
          byte_idx_nxt = 3'd0;
          byte_start   = 1'b1;
        end
      end
      ST_SEND: begin
        if (byte_done) begin
          if (byte_idx == 3'(FRAME_BYTES - 1)) begin
            state_nxt    = ST_IDLE;
            byte_idx_nxt = 3'd0;
          end else begin
            byte_idx_nxt = byte_idx + 3'd1;
            byte_start   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte mux: selects the frame byte about to be loaded into the serialiser.
  always_comb begin
    byte_data = SYNC_BYTE;
    case (byte_idx_nxt)
      3'd0:    byte_data = SYNC_BYTE;
      3'd1:    byte_data = code_q;
      3'd2:    byte_data = data_q[31:24];
      3'd3:    byte_data = data_q[23:16];
      3'd4:    byte_data = data_q[15:8];
      3'd5:    byte_data = data_q[7:0];
      3'd6:    byte_data = chk_q;
      default: byte_data = SYNC_BYTE;
    endcase
  end

  // State register, handshake ready flag and the report latched at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      byte_idx    <= '0;
      req_ready_q <= 1'b0;
      code_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
    end else begin
      state       <= state_nxt;
      byte_idx    <= byte_idx_nxt;
      req_ready_q <= (state_nxt == ST_IDLE);
      if (accept) begin
        code_q <= req_code;
        data_q <= req_data;
        chk_q  <= frame_checksum(req_code, req_data);
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

endmodule

// File: tb/tb_glitch_report_tx.sv
// Self-checking bench for glitch_report_tx: a UART line decoder reconstructs
// the bytes on tx and compares them to frames built from the report contents.
module tb_glitch_report_tx;

  localparam int BIT_CLKS = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_code = '0;
  logic [31:0] req_data = '0;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  bit   in_byte = 0;
  int   bstart = 0;
  logic [7:0] cur_byte = '0;
  logic [7:0] dec_q[$];
  int   bstart_q[$];
  int   acc_q[$];
  logic bit_q[$];
  int   stop_err = 0;
  int   busy_cnt = 0;
  bit   timing_en = 0;
  bit   t0_set = 0;
  int   t0 = 0;
  int   timing_bad = 0;
  int   trans_cnt = 0;
  logic prev_tx = 1'b1;

  glitch_report_tx #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_code (req_code),
    .req_data (req_data),
    .tx       (tx),
    .busy     (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter advanced on each active edge
  always @(posedge clk) cyc++;

  // Line monitor: handshake log, busy count, bit-edge timing and UART decode
  always @(negedge clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) acc_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
    if (timing_en && tx !== prev_tx) begin
      trans_cnt++;
      if (!t0_set) begin
        t0     = cyc;
        t0_set = 1;
      end else if (((cyc - t0) % BIT_CLKS) != 0) begin
        timing_bad++;
      end
    end
    prev_tx = tx;
    if (rst_n !== 1'b1) begin
      in_byte = 0;
    end else if (!in_byte) begin
      if (tx === 1'b0) begin
        in_byte = 1;
        bstart  = cyc;
        bstart_q.push_back(cyc);
      end
    end else if (((cyc - bstart) % BIT_CLKS) == BIT_CLKS / 2) begin
      int idx;
      idx = (cyc - bstart) / BIT_CLKS;
      if (idx >= 1 && idx <= 8) begin
        cur_byte = {tx, cur_byte[7:1]};
        bit_q.push_back(tx);
      end else if (idx == 9) begin
        if (tx !== 1'b1) stop_err++;
        dec_q.push_back(cur_byte);
        in_byte = 0;
      end
    end
  end

  // Watchdog so the bench can never hang
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, code, payload MSB first, then arithmetic sum mod 256
  function automatic logic [7:0] frame_byte(input logic [7:0] code, input logic [31:0] data,
                                            input int i);
    int sum;
    sum = int'(code) + int'(data[31:24]) + int'(data[23:16]) + int'(data[15:8]) + int'(data[7:0]);
    case (i)
      0: return 8'hA5;
      1: return code;
      2: return data[31:24];
      3: return data[23:16];
      4: return data[15:8];
      5: return data[7:0];
      default: return 8'(sum % 256);
    endcase
  endfunction

  task automatic check_output(input string tag, input int base,
                              input logic [7:0] code, input logic [31:0] data);
    logic [7:0] obs;
    for (int i = 0; i < 7; i++) begin
      obs = (base + i < dec_q.size()) ? dec_q[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, obs}, {24'd0, frame_byte(code, data, i)});
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code, input logic [31:0] data, input bit scramble);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_code  = code;
    req_data  = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (scramble) begin
        req_data = $urandom;
        req_code = 8'($urandom);
      end
      tick();
      n++;
    end
    chk("frame_end_busy", {31'd0, busy}, 32'd0);
    chk("frame_end_ready", {31'd0, req_ready}, 32'd1);
    chk("frame_end_tx", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [31:0] rd, d1, d2;
    logic [7:0]  sb;
    int          zeros;
    int          n;

    // Reset state
    repeat (3) tick();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Frame 1 with bit timing, sync bit order and busy length
    dec_q.delete(); bit_q.delete();
    busy_cnt  = 0;
    timing_en = 1;
    apply_stimulus(8'h01, 32'hDEADBEEF, 0);
    timing_en = 0;
    check_output("f1", 0, 8'h01, 32'hDEADBEEF);
    chk("f1_busy_cycles", busy_cnt, 700);
    chk("f1_timing_bad", timing_bad, 0);
    chk("f1_has_transitions", {31'd0, trans_cnt > 10}, 32'd1);
    sb = 'x;
    for (int i = 0; i < 8; i++) if (i < bit_q.size()) sb[i] = bit_q[i];
    chk("f1_sync_bits", {24'd0, sb}, {24'd0, 8'b10100101});

    // Checksum boundaries
    dec_q.delete();
    apply_stimulus(8'hFF, 32'hFFFFFFFF, 0);
    check_output("wrap", 0, 8'hFF, 32'hFFFFFFFF);
    chk("wrap_chk_const", {24'd0, (dec_q.size() > 6) ? dec_q[6] : 8'hxx}, 32'h000000FB);
    dec_q.delete();
    apply_stimulus(8'h00, 32'h0, 0);
    check_output("zero", 0, 8'h00, 32'h0);

    // Back-to-back with req_valid held high
    tick();
    dec_q.delete(); acc_q.delete(); bstart_q.delete();
    d1 = $urandom; d2 = $urandom;
    req_code = 8'h01; req_data = d1; req_valid = 1'b1;
    n = 0;
    while (acc_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    req_code = 8'h02; req_data = d2;
    repeat (1401) tick();
    req_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    tick();
    chk("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 1 && bstart_q.size() >= 8) begin
      chk("b2b_first_start", bstart_q[0] - acc_q[0], 1);
      chk("b2b_second_start", bstart_q[7] - acc_q[0], 702);
    end else begin
      chk("b2b_starts_seen", bstart_q.size(), 14);
    end
    check_output("b2b_a", 0, 8'h01, d1);
    check_output("b2b_b", 7, 8'h02, d2);

    // Inputs change every cycle during the frame
    dec_q.delete();
    rd = $urandom; rc = 8'($urandom);
    apply_stimulus(rc, rd, 1);
    check_output("scramble", 0, rc, rd);

    // Reset in the middle of byte 3
    dec_q.delete();
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    req_code = 8'h10; req_data = 32'h00000000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (335) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    zeros = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) zeros++;
    end
    chk("midrst_no_zero_bits", zeros, 0);
    dec_q.delete();
    rd = $urandom;
    apply_stimulus(8'hEE, rd, 0);
    check_output("after_rst", 0, 8'hEE, rd);

    // Random reports
    for (int k = 0; k < 3; k++) begin
      dec_q.delete();
      rc = 8'($urandom); rd = $urandom;
      apply_stimulus(rc, rd, k[0]);
      check_output($sformatf("rand%0d", k), 0, rc, rd);
    end

    chk("stop_bits", stop_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
